// File: rtl/ibwt_decode.sv
// rtl/ibwt_decode.sv - inverse Burrows-Wheeler transform decoder for one block of up to N bytes
//
// Ports:
//   clk          rising-edge clock
//   rst          synchronous active-low reset
//   start        decode request, sampled only while idle
//   data_in      BWT last column L, entry i = sorted row i
//   len          block length n, valid 1..N
//   primary_idx  sorted row holding the original string
//   busy         high while ranking or walking
//   done         one-cycle completion pulse
//   err          qualifies done when the request was invalid
//   data_out     reconstructed string, entry 0 = first character, unused entries 8'h00
module ibwt_decode #(
    parameter int N = 8
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       start,
    input  logic [7:0] data_in [0:N-1],
    input  logic [3:0] len,
    input  logic [2:0] primary_idx,
    output logic       busy,
    output logic       done,
    output logic       err,
    output logic [7:0] data_out [0:N-1]
);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RANK = 2'd1,
        S_WALK = 2'd2,
        S_DONE = 2'd3
    } state_t;

    state_t     state_q, state_d;
    logic [7:0] l_q    [0:N-1];
    logic [2:0] lf_q   [0:N-1];
    logic [7:0] out_q  [0:N-1];
    logic [3:0] len_q;
    logic [2:0] pidx_q;
    logic [2:0] rank_q;
    logic [2:0] idx_q;
    logic [2:0] k_q;
    logic       err_q;

    logic       invalid;
    logic       rank_last;
    logic       walk_last;
    logic [3:0] less_cnt;
    logic [3:0] occ_cnt;
    logic [2:0] lf_new;

    assign invalid   = (len == 4'd0) || (len > 4'(N)) || ({1'b0, primary_idx} >= len);
    assign rank_last = ({1'b0, rank_q} == (len_q - 4'd1));
    assign walk_last = (k_q == 3'd0);

    // LF[i] = number of symbols strictly smaller than L[i] plus the number of
    // equal symbols that precede it; entries beyond the block length are masked.
    always_comb begin
        less_cnt = 4'd0;
        occ_cnt  = 4'd0;
        for (int j = 0; j < N; j++) begin
            if (4'(j) < len_q) begin
                if (l_q[j] < l_q[rank_q]) begin
                    less_cnt = less_cnt + 4'd1;
                end
                if ((l_q[j] == l_q[rank_q]) && (4'(j) < {1'b0, rank_q})) begin
                    occ_cnt = occ_cnt + 4'd1;
                end
            end
        end
        lf_new = 3'(less_cnt + occ_cnt);
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q <= S_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE:  if (start) state_d = invalid ? S_DONE : S_RANK;
            S_RANK:  if (rank_last) state_d = S_WALK;
            S_WALK:  if (walk_last) state_d = S_DONE;
            S_DONE:  state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    always_comb begin
        busy = (state_q == S_RANK) || (state_q == S_WALK);
        done = (state_q == S_DONE);
        err  = (state_q == S_DONE) && err_q;
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            len_q  <= 4'd0;
            pidx_q <= 3'd0;
            rank_q <= 3'd0;
            idx_q  <= 3'd0;
            k_q    <= 3'd0;
            err_q  <= 1'b0;
            for (int i = 0; i < N; i++) begin
                l_q[i]   <= 8'h00;
                lf_q[i]  <= 3'd0;
                out_q[i] <= 8'h00;
            end
        end else begin
            case (state_q)
                S_IDLE: begin
                    if (start) begin
                        len_q  <= len;
                        pidx_q <= primary_idx;
                        rank_q <= 3'd0;
                        err_q  <= invalid;
                        for (int i = 0; i < N; i++) begin
                            l_q[i]   <= data_in[i];
                            lf_q[i]  <= 3'd0;
                            out_q[i] <= 8'h00;
                        end
                    end
                end
                S_RANK: begin
                    lf_q[rank_q] <= lf_new;
                    rank_q       <= rank_q + 3'd1;
                    if (rank_last) begin
                        idx_q <= pidx_q;
                        k_q   <= 3'(len_q - 4'd1);
                    end
                end
                S_WALK: begin
                    // Following LF from the primary row yields the string back to front.
                    out_q[k_q] <= l_q[idx_q];
                    idx_q      <= lf_q[idx_q];
                    k_q        <= k_q - 3'd1;
                end
                default: begin
                end
            endcase
        end
    end

    always_comb begin
        for (int i = 0; i < N; i++) begin
            data_out[i] = out_q[i];
        end
    end

endmodule

// File: doc/ibwt_decode.md
IBWT_DECODE -- requirements
Module: ibwt_decode

Interface
REQ-001 Parameter: N, default 8, maximum block length in bytes.
REQ-002 clk  input  1  sole clock; all state updates on rising edge.
REQ-003 rst  input  1  reset; synchronous, active-low.
REQ-004 start  input  1  request decode; sampled only in IDLE.
REQ-005 data_in  input  8 x [0:N-1]  BWT last column L, entry i = row i of the sorted rotation matrix.
REQ-006 len  input  4  block length n; valid range 1..N.
REQ-007 primary_idx  input  3  sorted-matrix row holding the original string.
REQ-008 busy  output  1  high while decoding.
REQ-009 done  output  1  one-cycle completion pulse.
REQ-010 err  output  1  high with done when inputs are invalid.
REQ-011 data_out  output  8 x [0:N-1]  reconstructed string; entry 0 = first character.

Function
REQ-012 States SHALL be IDLE, RANK, WALK, DONE.
REQ-013 IDLE to RANK when start=1. On that edge:
- latch data_in, len and primary_idx;
- clear data_out to all 8'h00;
- clear rank counter;
- busy goes high.
REQ-014 start SHALL be ignored in RANK, WALK and DONE. Inputs SHALL NOT be re-sampled while busy.
REQ-015 Invalid inputs: len=0, len>N, or primary_idx>=len. The start edge SHALL then go straight to DONE:
- err=1 with done;
- data_out stays all zero.
REQ-016 RANK SHALL process one index i per cycle, i=0..n-1. For each i it stores LF[i] = less(i) + occ(i):
- less(i) = count of j<n with L[j] < L[i], unsigned 8-bit compare;
- occ(i) = count of j<i with L[j] == L[i], stable for duplicates.
REQ-017 LF entries SHALL be 3 bits wide. Entries at index >=n SHALL be ignored in all comparisons.
REQ-018 After the n-th RANK cycle: go to WALK with idx=primary_idx and write pointer k=n-1.
REQ-019 Each WALK cycle SHALL:
- write data_out[k] = L[idx];
- set idx = LF[idx];
- decrement k.
There SHALL be exactly n WALK cycles.
REQ-020 On the edge writing k=0: done=1, busy=0, state goes to DONE.
REQ-021 DONE lasts one cycle, then IDLE with done=0 and err=0.
REQ-022 Latency: done SHALL be high 2n cycles after the start-sampling edge (16 for n=8). For invalid inputs it SHALL be high 1 cycle after.
REQ-023 data_out SHALL hold its value in IDLE until the next accepted start.
REQ-024 data_out entries with index >=n SHALL read 8'h00.
REQ-025 start held high continuously SHALL begin a new decode on the first IDLE cycle after DONE.

Reset
REQ-026 rst=0 at a rising edge SHALL force, at any state including mid-RANK or mid-WALK:
- state=IDLE;
- busy=0, done=0, err=0;
- data_out all 8'h00;
- LF table and counters cleared.
REQ-027 start SHALL be ignored during any cycle in which rst=0.
REQ-028 The first start after rst returns high SHALL be accepted normally.

Verification
REQ-029 data_in="nnbaaa", len=6, primary_idx=3, pulse start -> done 12 cycles later, err=0, data_out="banana" followed by two 8'h00.
REQ-030 data_in="bbbbaaaa", len=8, primary_idx=0 -> done 16 cycles later, data_out="abababab"; busy high for the 16 intervening cycles.
REQ-031 data_in="aaaaaaaa", len=8, primary_idx=5 -> data_out="aaaaaaaa", err=0.
REQ-032 len=1, data_in[0]="x", primary_idx=0 -> done after 2 cycles, data_out="x" followed by seven 8'h00.
REQ-033 len=5, primary_idx=6 -> done 1 cycle after start with err=1, data_out all zero; a second start pulse during busy of a valid decode has no effect.
REQ-034 rst=0 asserted during the WALK phase of the REQ-030 case -> busy=0, done never pulses, data_out all zero; a fresh start then yields "abababab" after 16 cycles.
